// File: rtl/cache_req_driver_pkg.sv
// rtl/cache_req_driver_pkg.sv - shared types and constants for the cache requester
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef enum logic {
    PH_WRITE,
    PH_READ
  } phase_t;

  // Write pattern is derived from the address so the read phase can recompute it.
  function automatic logic [WORD_W-1:0] gen_data(input logic [ADDR_W-1:0] addr,
                                                 input logic [WORD_W-1:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/cache_req_driver_if.sv
// rtl/cache_req_driver_if.sv - CPU-side request/response bus towards the cache
interface cache_req_driver_if;
  import cache_pkg::*;

  logic              rw;
  logic              valid_req;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] dataIn;
  logic              cache_ready;
  logic [WORD_W-1:0] dataOut;
  logic              hit;
  logic              miss;

  modport master (
    output rw, valid_req, addr, dataIn,
    input  cache_ready, dataOut, hit, miss
  );

  modport slave (
    input  rw, valid_req, addr, dataIn,
    output cache_ready, dataOut, hit, miss
  );

endinterface

// File: rtl/cache_req_driver_sat_counter.sv
// rtl/cache_req_driver_sat_counter.sv - clearable event counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_req_driver.sv
// rtl/cache_req_driver.sv - two-phase write-then-readback requester for the direct-mapped cache
module cache_req_driver
  import cache_pkg::*;
#(
  parameter int                NUM_REQ   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                STRIDE    = 4,
  parameter logic [WORD_W-1:0] DATA_SEED = 32'hA5A5_0000,
  parameter int                CNT_W     = 16,
  parameter int                TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  cache_req_driver_if.master bus,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int                IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam int                WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);

  state_t            state;
  phase_t            phase;
  logic [IDX_W-1:0]  idx;
  logic [WD_W-1:0]   wdog;
  logic [WORD_W-1:0] rdata;

  logic              run_start;
  logic              last_req;
  logic              mismatch;
  logic [ADDR_W-1:0] next_addr;

  assign run_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_req  = (idx == LAST_IDX);
  // Address advances incrementally; 32-bit addition gives the required wrap.
  assign next_addr = bus.addr + STEP;
  assign mismatch  = (state == ST_CHECK) && (phase == PH_READ) &&
                     (rdata != gen_data(bus.addr, DATA_SEED));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase         <= PH_WRITE;
      idx           <= '0;
      wdog          <= '0;
      rdata         <= '0;
      bus.valid_req <= 1'b0;
      bus.rw        <= 1'b0;
      bus.addr      <= '0;
      bus.dataIn    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_ISSUE;
            phase         <= PH_WRITE;
            idx           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            timeout       <= 1'b0;
            bus.valid_req <= 1'b1;
            bus.rw        <= RW_WRITE;
            bus.addr      <= BASE_ADDR;
            bus.dataIn    <= gen_data(BASE_ADDR, DATA_SEED);
          end
        end

        ST_ISSUE: begin
          // valid_req is always high here, so cache_ready alone marks the accept edge.
          if (bus.cache_ready) begin
            state         <= ST_WAIT;
            bus.valid_req <= 1'b0;
            wdog          <= '0;
          end
        end

        ST_WAIT: begin
          if (bus.cache_ready) begin
            state <= ST_CHECK;
            rdata <= bus.dataOut;
          end else if (wdog == WD_MAX) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        ST_CHECK: begin
          if (last_req && (phase == PH_READ)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state         <= ST_ISSUE;
            bus.valid_req <= 1'b1;
            if (last_req) begin
              phase      <= PH_READ;
              idx        <= '0;
              bus.rw     <= RW_READ;
              bus.addr   <= BASE_ADDR;
              bus.dataIn <= gen_data(BASE_ADDR, DATA_SEED);
            end else begin
              idx        <= idx + 1'b1;
              bus.addr   <= next_addr;
              bus.dataIn <= gen_data(next_addr, DATA_SEED);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_start),
    .inc   (busy && bus.hit),
    .cnt   (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_start),
    .inc   (busy && bus.miss),
    .cnt   (miss_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_start),
    .inc   (mismatch),
    .cnt   (err_cnt)
  );

endmodule
